// File: rtl/mod_button_event.sv
// Button gesture classifier: debounced level -> one-cycle short/double/long strobes, timed in tick_i units.
// Defining MOD_BUTTON_EVENT_REPEAT_EN adds auto-repeat strobes on repeat_o while held after a long press.
module mod_button_event #(
  parameter int unsigned LONG_MS   = 800,
  parameter int unsigned DBL_MS    = 300,
  parameter int unsigned REPEAT_MS = 200,
  parameter logic        ACT_LVL   = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic pin_i,
  output logic pressed_o,
  output logic short_o,
  output logic double_o,
  output logic long_o,
  output logic repeat_o,
  output logic busy_o
);

  localparam int unsigned MAX_A  = (LONG_MS > DBL_MS) ? LONG_MS : DBL_MS;
  localparam int unsigned MAX_MS = (MAX_A > REPEAT_MS) ? MAX_A : REPEAT_MS;
  localparam int unsigned CW     = $clog2(MAX_MS + 1);

  localparam logic [CW-1:0] C_LONG = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] C_DBL  = CW'(DBL_MS - 1);
`ifdef MOD_BUTTON_EVENT_REPEAT_EN
  localparam logic [CW-1:0] C_REP  = CW'(REPEAT_MS - 1);
`endif

  if (LONG_MS < 2 || DBL_MS < 2 || REPEAT_MS < 2) begin : g_bad_param
    $error("mod_button_event: LONG_MS, DBL_MS and REPEAT_MS must all be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_PRESS2,
    S_HELD
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_p;
  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_run;
  logic          w_short;
  logic          w_dbl;
  logic          w_long;
  logic          w_rep;
  logic          r_short;
  logic          r_dbl;
  logic          r_long;
  logic          r_rep;
  logic          r_busy;

  always_comb begin
    w_nxt   = r_state;
    w_run   = 1'b0;
    w_short = 1'b0;
    w_dbl   = 1'b0;
    w_long  = 1'b0;
    w_rep   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_p) w_nxt = S_PRESS1;
      end
      S_PRESS1: begin
        w_run = 1'b1;
        // A release in the threshold cycle beats the long-press decision.
        if (!r_p) begin
          w_nxt = S_GAP;
        end else if (tick_i && r_cnt == C_LONG) begin
          w_long = 1'b1;
          w_nxt  = S_HELD;
        end
      end
      S_GAP: begin
        w_run = 1'b1;
        if (r_p) begin
          w_nxt = S_PRESS2;
        end else if (tick_i && r_cnt == C_DBL) begin
          w_short = 1'b1;
          w_nxt   = S_IDLE;
        end
      end
      S_PRESS2: begin
        w_run = 1'b1;
        if (!r_p) begin
          w_dbl = 1'b1;
          w_nxt = S_IDLE;
        end else if (tick_i && r_cnt == C_LONG) begin
          w_dbl = 1'b1;
          w_nxt = S_HELD;
        end
      end
      S_HELD: begin
        if (!r_p) begin
          w_nxt = S_IDLE;
        end
`ifdef MOD_BUTTON_EVENT_REPEAT_EN
        else begin
          w_run = 1'b1;
          if (tick_i && r_cnt == C_REP) w_rep = 1'b1;
        end
`endif
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Any state change (or a repeat strobe) restarts the interval; saturate instead of wrapping.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_nxt != r_state || w_rep) begin
      w_cnt_nxt = '0;
    end else if (w_run && tick_i && r_cnt != {CW{1'b1}}) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= ~ACT_LVL;
      r_sync2 <= ~ACT_LVL;
      r_p     <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_short <= 1'b0;
      r_dbl   <= 1'b0;
      r_long  <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_sync1 <= pin_i;
      r_sync2 <= r_sync1;
      r_p     <= (r_sync2 == ACT_LVL);
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_nxt != S_IDLE);
      r_short <= w_short;
      r_dbl   <= w_dbl;
      r_long  <= w_long;
      r_rep   <= w_rep;
    end
  end

  assign pressed_o = r_p;
  assign short_o   = r_short;
  assign double_o  = r_dbl;
  assign long_o    = r_long;
  assign repeat_o  = r_rep;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_mod_button_event.sv
// Directed bench for mod_button_event with a gesture-level reference model and literal timing pins.
`timescale 1ns/1ps
module tb_mod_button_event;

  localparam int L = 8;
  localparam int D = 4;
  localparam int R = 3;
`ifdef MOD_BUTTON_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, tick, pin;
  logic pressed_o, short_o, double_o, long_o, repeat_o, busy_o;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit done = 1'b0;

  int q_short[$], q_dbl[$], q_long[$], q_rep[$];
  string lit_nm[$];
  int lit_act[$], lit_exp[$];
  int lit_rd = 0;

  mod_button_event #(
    .LONG_MS(L), .DBL_MS(D), .REPEAT_MS(R), .ACT_LVL(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .pin_i(pin),
    .pressed_o(pressed_o), .short_o(short_o), .double_o(double_o),
    .long_o(long_o), .repeat_o(repeat_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gesture model: counts presses in the current gesture and ticks elapsed in the current phase.
  bit m_s1, m_s2, m_pp;
  int g_n, g_el;
  bit g_down, g_held;
  bit e_short, e_dbl, e_long, e_rep;

  always @(posedge clk) begin : model
    bit pm;
    pm = m_pp;
    e_short = 1'b0; e_dbl = 1'b0; e_long = 1'b0; e_rep = 1'b0;
    if (rst === 1'b1) begin
      m_s1 = 0; m_s2 = 0; m_pp = 0;
      g_n = 0; g_el = 0; g_down = 0; g_held = 0;
    end else begin
      m_pp = m_s2; m_s2 = m_s1; m_s1 = (pin === 1'b1);
      if (g_n == 0) begin
        if (pm) begin g_n = 1; g_down = 1; g_held = 0; g_el = 0; end
      end else if (g_held) begin
        if (!pm) g_n = 0;
        else if (REP_EN && tick) begin
          g_el++;
          if (g_el == R) begin e_rep = 1; g_el = 0; end
        end
      end else if (g_down) begin
        if (!pm) begin
          if (g_n == 2) begin e_dbl = 1; g_n = 0; end
          else begin g_down = 0; g_el = 0; end
        end else if (tick) begin
          g_el++;
          if (g_el == L) begin
            g_held = 1; g_el = 0;
            if (g_n == 1) e_long = 1; else e_dbl = 1;
          end
        end
      end else begin
        if (pm) begin g_n = 2; g_down = 1; g_el = 0; end
        else if (tick) begin
          g_el++;
          if (g_el == D) begin e_short = 1; g_n = 0; end
        end
      end
    end
  end

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  // Single checking process: per-cycle model compares plus queued literal expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("pressed_o", pressed_o, m_pp);
      check1("busy_o", busy_o, g_n != 0);
      check1("short_o", short_o, e_short);
      check1("double_o", double_o, e_dbl);
      check1("long_o", long_o, e_long);
      check1("repeat_o", repeat_o, e_rep);
      check1("at_most_one_event", $countones({short_o, double_o, long_o, repeat_o}) <= 1, 1'b1);
      if (short_o === 1'b1) q_short.push_back(cyc);
      if (double_o === 1'b1) q_dbl.push_back(cyc);
      if (long_o === 1'b1) q_long.push_back(cyc);
      if (repeat_o === 1'b1) q_rep.push_back(cyc);
    end
    while (lit_rd < lit_nm.size()) begin
      n_chk++;
      if (lit_act[lit_rd] != lit_exp[lit_rd]) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d", lit_nm[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      end
      lit_rd++;
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    lit_nm.push_back(nm);
    lit_act.push_back(act);
    lit_exp.push_back(exp);
  endtask

  function automatic int nth(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic p, input logic t);
    pin = p;
    tick = t;
    step();
  endtask

  task automatic do_reset();
    pin = 1'b0; tick = 1'b0; rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
  endtask

  task automatic snap(output int s, output int d, output int l, output int r);
    s = q_short.size(); d = q_dbl.size(); l = q_long.size(); r = q_rep.size();
  endtask

  initial begin
    int c, bs, bd, bl, br;
    rst = 1'b1; pin = 1'b1; tick = 1'b0;
    step();
    chk_en = 1'b1;
    repeat (4) step();

    // Button held through reset release: seen as a fresh press.
    rst = 1'b0;
    repeat (2) step();
    lit("rst_pressed_early", int'(pressed_o), 0);
    repeat (2) step();
    lit("rst_pressed_c4", int'(pressed_o), 1);
    lit("rst_busy_c4", int'(busy_o), 1);
    do_reset();

    // Short press
    c = cyc; snap(bs, bd, bl, br);
    repeat (3) drv(1'b1, 1'b1);
    repeat (15) drv(1'b0, 1'b1);
    lit("short_n", q_short.size() - bs, 1);
    lit("short_at", nth(q_short, bs), c + 11);
    lit("short_no_dbl", q_dbl.size() - bd, 0);
    lit("short_no_long", q_long.size() - bl, 0);

    // Double click
    c = cyc; snap(bs, bd, bl, br);
    repeat (2) drv(1'b1, 1'b1);
    repeat (2) drv(1'b0, 1'b1);
    repeat (2) drv(1'b1, 1'b1);
    repeat (12) drv(1'b0, 1'b1);
    lit("dbl_n", q_dbl.size() - bd, 1);
    lit("dbl_at", nth(q_dbl, bd), c + 10);
    lit("dbl_no_short", q_short.size() - bs, 0);
    lit("dbl_busy_end", int'(busy_o), 0);

    // Long press with optional auto-repeat
    c = cyc; snap(bs, bd, bl, br);
    repeat (20) drv(1'b1, 1'b1);
    repeat (10) drv(1'b0, 1'b1);
    lit("long_n", q_long.size() - bl, 1);
    lit("long_at", nth(q_long, bl), c + 12);
    lit("long_no_short", q_short.size() - bs, 0);
    lit("long_rep_n", q_rep.size() - br, REP_EN ? 3 : 0);
    lit("long_rep_first", nth(q_rep, br), REP_EN ? c + 15 : -1);

    // Release coincident with the long-press threshold tick (tick every 4th cycle)
    c = cyc; snap(bs, bd, bl, br);
    for (int i = 0; i < 60; i++) drv(i < 32, ((i + 1) % 4) == 0);
    lit("coin_no_long", q_long.size() - bl, 0);
    lit("coin_short_n", q_short.size() - bs, 1);
    lit("coin_short_at", nth(q_short, bs), c + 52);

    // Reset during GAP discards the gesture
    snap(bs, bd, bl, br);
    for (int i = 0; i < 7; i++) drv(i < 3, 1'b1);
    rst = 1'b1;
    repeat (2) drv(1'b0, 1'b1);
    rst = 1'b0;
    repeat (15) drv(1'b0, 1'b1);
    lit("gaprst_no_short", q_short.size() - bs, 0);
    lit("gaprst_busy", int'(busy_o), 0);

    // Second press held past the threshold: double via timeout, no long
    c = cyc; snap(bs, bd, bl, br);
    repeat (2) drv(1'b1, 1'b1);
    repeat (2) drv(1'b0, 1'b1);
    repeat (15) drv(1'b1, 1'b1);
    repeat (10) drv(1'b0, 1'b1);
    lit("p2to_dbl_n", q_dbl.size() - bd, 1);
    lit("p2to_dbl_at", nth(q_dbl, bd), c + 16);
    lit("p2to_no_long", q_long.size() - bl, 0);
    lit("p2to_rep_n", q_rep.size() - br, REP_EN ? 2 : 0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
